// File: rtl/isa_pkg.sv
// Shared definitions for the ISA reference stepper: opcodes, instruction field
// positions, the instruction-width derivation and the FSM state encoding.
package isa_pkg;

    localparam logic [2:0] OP_LI   = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_LD   = 3'd3;
    localparam logic [2:0] OP_BR   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    localparam int OP_W = 3;

    typedef enum logic [1:0] {
        LOAD,
        FETCH,
        COMMIT,
        HALTED
    } state_t;

    // Word layout, MSB first: {opcode, rs1_imm, rs2, rd}.
    function automatic int inst_len(input int reg_len, input int rf_size_log);
        return OP_W + reg_len + 2 * rf_size_log;
    endfunction

    function automatic int rd_lsb();
        return 0;
    endfunction

    function automatic int rs2_lsb(input int rf_size_log);
        return rf_size_log;
    endfunction

    function automatic int imm_lsb(input int rf_size_log);
        return 2 * rf_size_log;
    endfunction

    function automatic int op_lsb(input int reg_len, input int rf_size_log);
        return reg_len + 2 * rf_size_log;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/isa_ref_exec.sv
// Combinational decode/execute for one instruction. Record fields that an
// instruction does not use (rd/data when not writing, store fields when not
// storing) are driven to zero so commit records compare cleanly.
module isa_ref_exec
    import isa_pkg::*;
#(
    parameter int REG_LEN       = 4,
    parameter int RF_SIZE_LOG   = 2,
    parameter int MEMI_SIZE_LOG = 3,
    parameter int MEMD_SIZE_LOG = 2,
    localparam int INST_LEN     = inst_len(REG_LEN, RF_SIZE_LOG)
) (
    input  logic [INST_LEN-1:0]      inst,
    input  logic [MEMI_SIZE_LOG-1:0] pc,
    input  logic [REG_LEN-1:0]       rs1_val,
    input  logic [REG_LEN-1:0]       rs2_val,
    input  logic [REG_LEN-1:0]       ld_val,
    output logic [RF_SIZE_LOG-1:0]   rs1,
    output logic [RF_SIZE_LOG-1:0]   rs2,
    output logic [MEMD_SIZE_LOG-1:0] ld_addr,
    output logic                     wen,
    output logic [RF_SIZE_LOG-1:0]   rd,
    output logic [REG_LEN-1:0]       rd_data,
    output logic                     mem_we,
    output logic [MEMD_SIZE_LOG-1:0] mem_addr,
    output logic [REG_LEN-1:0]       mem_data,
    output logic [MEMI_SIZE_LOG-1:0] next_pc,
    output logic                     halt
);

    localparam int OP_LSB  = op_lsb(REG_LEN, RF_SIZE_LOG);
    localparam int IMM_LSB = imm_lsb(RF_SIZE_LOG);
    localparam int RS2_LSB = rs2_lsb(RF_SIZE_LOG);
    localparam int RD_LSB  = rd_lsb();

    logic [2:0]               op;
    logic [REG_LEN-1:0]       imm;
    logic [RF_SIZE_LOG-1:0]   rd_field;
    logic [MEMI_SIZE_LOG-1:0] br_offset;

    assign op        = inst[OP_LSB +: OP_W];
    assign imm       = inst[IMM_LSB +: REG_LEN];
    assign rs2       = inst[RS2_LSB +: RF_SIZE_LOG];
    assign rd_field  = inst[RD_LSB +: RF_SIZE_LOG];
    assign rs1       = imm[RF_SIZE_LOG-1:0];
    assign br_offset = imm[MEMI_SIZE_LOG-1:0];
    assign ld_addr   = rs1_val[MEMD_SIZE_LOG-1:0];

    always_comb begin
        wen      = 1'b0;
        rd       = '0;
        rd_data  = '0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        next_pc  = pc + MEMI_SIZE_LOG'(1);
        halt     = 1'b0;
        case (op)
            OP_LI: begin
                wen     = 1'b1;
                rd      = rd_field;
                rd_data = imm;
            end
            OP_ADD: begin
                wen     = 1'b1;
                rd      = rd_field;
                rd_data = rs1_val + rs2_val;
            end
            OP_MUL: begin
                wen     = 1'b1;
                rd      = rd_field;
                rd_data = rs1_val * rs2_val;
            end
            OP_LD: begin
                wen     = 1'b1;
                rd      = rd_field;
                rd_data = ld_val;
            end
            OP_BR: begin
                if (rs2_val == '0)
                    next_pc = pc + br_offset;
            end
            OP_ST: begin
                mem_we   = 1'b1;
                mem_addr = rs1_val[MEMD_SIZE_LOG-1:0];
                mem_data = rs2_val;
            end
            OP_HALT: begin
                next_pc = pc;
                halt    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/isa_ref_stepper.sv
// Handshaked ISA golden model: load phase, then one instruction per FETCH/COMMIT
// pair. Architectural state (rf, memd, pc, retired) moves only when a record fires.
module isa_ref_stepper
    import isa_pkg::*;
#(
    parameter int REG_LEN       = 4,
    parameter int RF_SIZE_LOG   = 2,
    parameter int MEMI_SIZE_LOG = 3,
    parameter int MEMD_SIZE_LOG = 2,
    parameter int CNT_W         = 16,
    localparam int INST_LEN     = inst_len(REG_LEN, RF_SIZE_LOG),
    localparam int ADDR_W       = max_int(MEMI_SIZE_LOG, MEMD_SIZE_LOG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_memi_we,
    input  logic                     load_memd_we,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [INST_LEN-1:0]      load_data,
    input  logic                     start,
    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic [MEMI_SIZE_LOG-1:0] commit_pc,
    output logic [INST_LEN-1:0]      commit_inst,
    output logic                     commit_wen,
    output logic [RF_SIZE_LOG-1:0]   commit_rd,
    output logic [REG_LEN-1:0]       commit_rd_data,
    output logic                     commit_mem_we,
    output logic [MEMD_SIZE_LOG-1:0] commit_mem_addr,
    output logic [REG_LEN-1:0]       commit_mem_data,
    output logic [MEMI_SIZE_LOG-1:0] commit_next_pc,
    output logic                     halted,
    output logic [CNT_W-1:0]         retired
);

    localparam int MEMI_DEPTH = 2 ** MEMI_SIZE_LOG;
    localparam int MEMD_DEPTH = 2 ** MEMD_SIZE_LOG;
    localparam int RF_DEPTH   = 2 ** RF_SIZE_LOG;

    state_t state, state_next;

    logic [INST_LEN-1:0]      memi [MEMI_DEPTH];
    logic [REG_LEN-1:0]       memd [MEMD_DEPTH];
    logic [REG_LEN-1:0]       rf   [RF_DEPTH];
    logic [MEMI_SIZE_LOG-1:0] pc;
    logic                     rec_halt;
    logic                     fire;
    logic                     load_phase;

    logic [INST_LEN-1:0]      inst;
    logic [RF_SIZE_LOG-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic [MEMD_SIZE_LOG-1:0] ex_ld_addr, ex_mem_addr;
    logic                     ex_wen, ex_mem_we, ex_halt;
    logic [REG_LEN-1:0]       ex_rd_data, ex_mem_data;
    logic [MEMI_SIZE_LOG-1:0] ex_next_pc;

    assign commit_valid = (state == COMMIT);
    assign halted       = (state == HALTED);
    assign fire         = commit_valid && commit_ready;
    assign load_phase   = (state == LOAD) && !rst;
    assign inst         = memi[pc];

    isa_ref_exec #(
        .REG_LEN       (REG_LEN),
        .RF_SIZE_LOG   (RF_SIZE_LOG),
        .MEMI_SIZE_LOG (MEMI_SIZE_LOG),
        .MEMD_SIZE_LOG (MEMD_SIZE_LOG)
    ) u_exec (
        .inst     (inst),
        .pc       (pc),
        .rs1_val  (rf[ex_rs1]),
        .rs2_val  (rf[ex_rs2]),
        .ld_val   (memd[ex_ld_addr]),
        .rs1      (ex_rs1),
        .rs2      (ex_rs2),
        .ld_addr  (ex_ld_addr),
        .wen      (ex_wen),
        .rd       (ex_rd),
        .rd_data  (ex_rd_data),
        .mem_we   (ex_mem_we),
        .mem_addr (ex_mem_addr),
        .mem_data (ex_mem_data),
        .next_pc  (ex_next_pc),
        .halt     (ex_halt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (start) state_next = FETCH;
            FETCH:   state_next = COMMIT;
            COMMIT:  if (fire) state_next = rec_halt ? HALTED : FETCH;
            HALTED:  state_next = HALTED;
            default: state_next = LOAD;
        endcase
    end

    // Memories keep their contents across reset so a program can be rerun.
    always_ff @(posedge clk) begin
        if (load_phase && load_memi_we)
            memi[load_addr[MEMI_SIZE_LOG-1:0]] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (load_phase && load_memd_we)
            memd[load_addr[MEMD_SIZE_LOG-1:0]] <= load_data[REG_LEN-1:0];
        else if (!rst && fire && commit_mem_we)
            memd[commit_mem_addr] <= commit_mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= '0;
            retired         <= '0;
            rec_halt        <= 1'b0;
            commit_pc       <= '0;
            commit_inst     <= '0;
            commit_wen      <= 1'b0;
            commit_rd       <= '0;
            commit_rd_data  <= '0;
            commit_mem_we   <= 1'b0;
            commit_mem_addr <= '0;
            commit_mem_data <= '0;
            commit_next_pc  <= '0;
            for (int i = 0; i < RF_DEPTH; i++)
                rf[i] <= '0;
        end else begin
            // Record is captured once in FETCH and held untouched through COMMIT.
            if (state == FETCH) begin
                commit_pc       <= pc;
                commit_inst     <= inst;
                commit_wen      <= ex_wen;
                commit_rd       <= ex_rd;
                commit_rd_data  <= ex_rd_data;
                commit_mem_we   <= ex_mem_we;
                commit_mem_addr <= ex_mem_addr;
                commit_mem_data <= ex_mem_data;
                commit_next_pc  <= ex_next_pc;
                rec_halt        <= ex_halt;
            end
            if (fire) begin
                if (commit_wen)
                    rf[commit_rd] <= commit_rd_data;
                pc <= commit_next_pc;
                if (retired != '1)
                    retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_isa_ref_stepper.sv
// Scoreboard bench: an integer-arithmetic ISA model queues expected commit records
// on stimulus; a negedge monitor compares whatever the DUT presents.
module tb_isa_ref_stepper;

    localparam int REG_LEN = 4;
    localparam int RF      = 2;
    localparam int MI      = 3;
    localparam int MD      = 2;
    localparam int CNT_W   = 16;
    localparam int IL      = 3 + REG_LEN + 2 * RF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_memi_we = 1'b0;
    logic              load_memd_we = 1'b0;
    logic [2:0]        load_addr = '0;
    logic [IL-1:0]     load_data = '0;
    logic              start = 1'b0;
    logic              commit_valid;
    logic              commit_ready = 1'b0;
    logic [MI-1:0]     commit_pc;
    logic [IL-1:0]     commit_inst;
    logic              commit_wen;
    logic [RF-1:0]     commit_rd;
    logic [REG_LEN-1:0] commit_rd_data;
    logic              commit_mem_we;
    logic [MD-1:0]     commit_mem_addr;
    logic [REG_LEN-1:0] commit_mem_data;
    logic [MI-1:0]     commit_next_pc;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    always #5 clk = ~clk;

    isa_ref_stepper #(
        .REG_LEN(REG_LEN), .RF_SIZE_LOG(RF), .MEMI_SIZE_LOG(MI),
        .MEMD_SIZE_LOG(MD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .load_memi_we(load_memi_we), .load_memd_we(load_memd_we),
        .load_addr(load_addr), .load_data(load_data), .start(start),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_rd_data(commit_rd_data),
        .commit_mem_we(commit_mem_we), .commit_mem_addr(commit_mem_addr),
        .commit_mem_data(commit_mem_data), .commit_next_pc(commit_next_pc),
        .halted(halted), .retired(retired)
    );

    typedef struct {
        int pc, inst, wen, rd, rd_data, mem_we, mem_addr, mem_data, next_pc;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_fire = 0;
    int   fire_limit = 0;
    bit   rand_ready = 1'b0;

    // Architectural model: plain integers, modular arithmetic.
    int m_memi[8];
    int m_memd[4];
    int m_rf[4];
    int m_pc = 0;
    bit m_halted = 1'b0;
    int prog[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int enc(input int op, input int imm, input int rs2, input int rd);
        return op * 256 + imm * 16 + rs2 * 4 + rd;
    endfunction

    task automatic model_peek(output rec_t r);
        int inst, op, imm, rs2, rd, a, b;
        inst = m_memi[m_pc];
        op   = inst / 256;
        imm  = (inst / 16) % 16;
        rs2  = (inst / 4) % 4;
        rd   = inst % 4;
        a    = m_rf[imm % 4];
        b    = m_rf[rs2];
        r = '{pc: m_pc, inst: inst, wen: 0, rd: 0, rd_data: 0, mem_we: 0,
              mem_addr: 0, mem_data: 0, next_pc: (m_pc + 1) % 8};
        case (op)
            0: begin r.wen = 1; r.rd = rd; r.rd_data = imm; end
            1: begin r.wen = 1; r.rd = rd; r.rd_data = (a + b) % 16; end
            2: begin r.wen = 1; r.rd = rd; r.rd_data = (a * b) % 16; end
            3: begin r.wen = 1; r.rd = rd; r.rd_data = m_memd[a % 4]; end
            4: if (b == 0) r.next_pc = (m_pc + imm % 8) % 8;
            5: begin r.mem_we = 1; r.mem_addr = a % 4; r.mem_data = b; end
            6: r.next_pc = m_pc;
            default: ;
        endcase
    endtask

    task automatic model_apply(input rec_t r);
        if (r.wen != 0) m_rf[r.rd] = r.rd_data;
        if (r.mem_we != 0) m_memd[r.mem_addr] = r.mem_data;
        m_pc = r.next_pc;
        if (r.inst / 256 == 6) m_halted = 1'b1;
    endtask

    // Monitor: any presented record must match the queue head; pop on fire.
    always @(negedge clk) begin
        if (!rst && commit_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit_pc", commit_pc, -1);
            end else begin
                mon_e = exp_q[0];
                chk("commit_pc", commit_pc, mon_e.pc);
                chk("commit_inst", commit_inst, mon_e.inst);
                chk("commit_wen", commit_wen, mon_e.wen);
                chk("commit_rd", commit_rd, mon_e.rd);
                chk("commit_rd_data", commit_rd_data, mon_e.rd_data);
                chk("commit_mem_we", commit_mem_we, mon_e.mem_we);
                chk("commit_mem_addr", commit_mem_addr, mon_e.mem_addr);
                chk("commit_mem_data", commit_mem_data, mon_e.mem_data);
                chk("commit_next_pc", commit_next_pc, mon_e.next_pc);
                chk("retired_before_fire", retired, n_fire);
                if (commit_ready) begin
                    void'(exp_q.pop_front());
                    n_fire++;
                end
            end
        end
    end

    // Ready driver: fire_limit caps how many records may be accepted.
    always @(posedge clk) begin
        #1;
        commit_ready = (n_fire < fire_limit) && (!rand_ready || ($urandom_range(0, 2) != 0));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fire_limit = 0;
        rst = 1'b1;
        tick(2);
        exp_q.delete();
        n_fire = 0;
        chk("rst_valid", commit_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retired", retired, 0);
        chk("rst_commit_pc", commit_pc, 0);
        chk("rst_commit_rd_data", commit_rd_data, 0);
        chk("rst_commit_next_pc", commit_next_pc, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        m_pc = 0;
        m_halted = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 8; i++) begin
            load_memi_we = 1'b1;
            load_addr = 3'(i);
            load_data = IL'(prog[i]);
            tick();
            m_memi[i] = prog[i];
        end
        load_memi_we = 1'b0;
    endtask

    task automatic load_memd(input int addr, input int val);
        load_memd_we = 1'b1;
        load_addr = 3'(addr);
        load_data = IL'(val);
        tick();
        load_memd_we = 1'b0;
        m_memd[addr] = val % 16;
    endtask

    // Runs the model up to max_steps; an unhalted run ends with a pending record
    // that is discarded by reset. stall holds ready low and strobes memi meanwhile.
    task automatic run_prog(input int max_steps, input bit rnd, input bit stall);
        rec_t r;
        int k, budget;
        k = 0;
        while (!m_halted && k < max_steps) begin
            model_peek(r);
            exp_q.push_back(r);
            model_apply(r);
            k++;
        end
        if (!m_halted) begin
            model_peek(r);
            exp_q.push_back(r);
        end
        rand_ready = rnd;
        fire_limit = stall ? 0 : k;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (stall) begin
            load_memi_we = 1'b1;
            load_addr = 3'd2;
            load_data = IL'(enc(7, 0, 0, 0));
        end
        chk("fetch_valid", commit_valid, 0);
        tick();
        chk("start_latency_valid", commit_valid, 1);
        if (stall) begin
            tick(5);
            chk("stall_valid", commit_valid, 1);
            chk("stall_no_fire", retired, 0);
            load_memi_we = 1'b0;
            fire_limit = k;
        end
        budget = 40 * k + 100;
        while (n_fire < k && budget > 0) begin
            tick();
            budget--;
        end
        chk("fires_done", n_fire, k);
        if (m_halted) begin
            budget = 20;
            while (!halted && budget > 0) begin
                tick();
                budget--;
            end
            chk("halted", halted, 1);
            tick();
            chk("halted_valid", commit_valid, 0);
            chk("halted_retired", retired, k);
            chk("queue_drained", exp_q.size(), 0);
        end else begin
            tick(3);
            chk("pending_valid", commit_valid, 1);
            chk("pending_retired", retired, k);
            do_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        for (int i = 0; i < 8; i++) m_memi[i] = 0;
        for (int i = 0; i < 4; i++) m_memd[i] = 0;
        do_reset();
        for (int i = 0; i < 4; i++) load_memd(i, 0);

        // LI r1,3; LI r2,5; ADD r3,r1,r2; HALT
        prog = '{enc(0,3,0,1), enc(0,5,0,2), enc(1,1,2,3), enc(6,0,0,0),
                 enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0)};
        load_prog();
        run_prog(20, 1'b0, 1'b0);
        chk("prog1_retired", retired, 4);
        // start and load strobes after HALT are ignored
        start = 1'b1; load_memd_we = 1'b1; load_addr = 3'd0; load_data = IL'(15);
        tick();
        start = 1'b0; load_memd_we = 1'b0;
        tick(3);
        chk("post_halt_halted", halted, 1);
        chk("post_halt_valid", commit_valid, 0);

        // LI r1,7; MUL r2,r1,r1 (49 mod 16); HALT at pc 2, tampered during stall
        do_reset();
        prog = '{enc(0,7,0,1), enc(2,1,1,2), enc(6,0,0,0), enc(7,0,0,0),
                 enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0)};
        load_prog();
        run_prog(20, 1'b0, 1'b1);

        // ST [r1]<-r2 at addr 2 with 9, then LD back
        do_reset();
        prog = '{enc(0,2,0,1), enc(0,9,0,2), enc(5,1,2,0), enc(3,1,0,3),
                 enc(6,0,0,0), enc(7,0,0,0), enc(7,0,0,0), enc(7,0,0,0)};
        load_prog();
        run_prog(20, 1'b1, 1'b0);

        // BR at pc 6 offset 3: taken wraps to 1, then not taken to 7
        do_reset();
        prog = '{enc(4,6,0,0), enc(0,1,0,2), enc(4,4,3,0), enc(7,0,0,0),
                 enc(7,0,0,0), enc(7,0,0,0), enc(4,3,2,0), enc(6,0,0,0)};
        load_prog();
        run_prog(20, 1'b1, 1'b0);

        // Reset while a store is pending; the rerun's first LD sees only fired stores
        do_reset();
        load_memd(0, 5);
        prog = '{enc(3,0,0,3), enc(0,0,0,1), enc(0,6,0,2), enc(5,1,2,0),
                 enc(0,3,0,2), enc(5,1,2,0), enc(6,0,0,0), enc(7,0,0,0)};
        load_prog();
        run_prog(5, 1'b0, 1'b0);
        run_prog(20, 1'b1, 1'b0);

        // Random programs and data, random backpressure
        for (int t = 0; t < 8; t++) begin
            do_reset();
            for (int i = 0; i < 4; i++) load_memd(i, $urandom_range(0, 15));
            for (int i = 0; i < 8; i++) begin
                op = $urandom_range(0, 7);
                prog[i] = enc(op, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            load_prog();
            run_prog(30, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/isa_ref_stepper.md
# isa_ref_stepper

Parametrised, handshaked successor of the single-cycle ISA golden model. It executes one architectural instruction per step and presents each step as a registered commit record on a valid/ready port, so a lockstep checker can compare it against the out-of-order core's retirement stream. Compared with the previous model it adds:
- a program/data load phase;
- a store instruction and a HALT instruction;
- a retired-instruction counter.

## Interface
- REG_LEN, 4: data register width; also the width of the imm/rs1 field.
- RF_SIZE_LOG, 2: log2 of the register-file entry count.
- MEMI_SIZE_LOG, 3: log2 of the instruction-memory depth; this is the pc width.
- MEMD_SIZE_LOG, 2: log2 of the data-memory depth.
- CNT_W, 16: width of the retired-instruction counter.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- load_memi_we  in  1  instruction-memory write strobe; honoured only in LOAD.
- load_memd_we  in  1  data-memory write strobe; honoured only in LOAD.
- load_addr  in  max(MEMI_SIZE_LOG,MEMD_SIZE_LOG)  load address; the low bits are used per target memory.
- load_data  in  INST_LEN  load data; data memory uses the low REG_LEN bits.
- start  in  1  moves the FSM from LOAD to FETCH.
- commit_valid  out  1  commit record valid.
- commit_ready  in  1  consumer accepts the commit record.
- commit_pc  out  MEMI_SIZE_LOG  pc of the committing instruction.
- commit_inst  out  INST_LEN  raw instruction word.
- commit_wen, commit_rd, commit_rd_data  out  1/RF_SIZE_LOG/REG_LEN  register write.
- commit_mem_we, commit_mem_addr, commit_mem_data  out  1/MEMD_SIZE_LOG/REG_LEN  store.
- commit_next_pc  out  MEMI_SIZE_LOG  pc after this instruction.
- halted  out  1  high in the HALTED state.
- retired  out  CNT_W  count of accepted commits; saturates at all-ones.

## Operation
- Instruction format, INST_LEN = 3+REG_LEN+2·RF_SIZE_LOG: {opcode[2:0], rs1_imm[REG_LEN], rs2, rd}.
  - rs1 is the low RF_SIZE_LOG bits of rs1_imm.
  - br_offset is the low MEMI_SIZE_LOG bits of rs1_imm.
- Opcodes:
  - LI=0: rd←imm.
  - ADD=1: rd←rf[rs1]+rf[rs2].
  - MUL=2: rd←rf[rs1]·rf[rs2].
  - LD=3: rd←memd[rf[rs1][MEMD_SIZE_LOG-1:0]].
  - BR=4: next_pc = pc+br_offset if rf[rs2]==0, else pc+1.
  - ST=5: memd[rf[rs1] low bits]←rf[rs2].
  - HALT=6: no writes; next_pc=pc.
  - 7: NOP, which advances pc only.
- Arithmetic: ADD and MUL results are truncated to REG_LEN bits. pc arithmetic wraps modulo 2^MEMI_SIZE_LOG.
- FSM states:
  - LOAD, entered on reset: load writes accepted. start → FETCH.
  - FETCH: decode and execute the instruction at pc from current state, latch the commit record → COMMIT.
  - COMMIT: commit_valid=1. On valid&&ready (fire), update rf, memd, pc and retired. Opcode HALT → HALTED; otherwise → FETCH.
  - HALTED: no further activity until reset.
- Record stability: the record is stable while valid && !ready. Architectural state changes only on fire.
- Ignored inputs: load strobes outside LOAD; start outside LOAD. A load strobe in the same cycle as start is still performed.
- A destination rd equal to rs1 or rs2 uses the old source values.
- ST followed by LD to the same address returns the stored value.

## Timing
- Reset values:
  - commit_valid=0, halted=0, retired=0, pc=0, all rf entries 0.
  - All commit_* data outputs are 0.
  - memi and memd are NOT cleared by reset.
- Reset mid-COMMIT discards the pending record with no architectural update.
- start at cycle t: FETCH at t+1, commit_valid=1 from t+2.
- Throughput: one instruction per 2 cycles when commit_ready is held high.
- Fire at cycle t: new state visible at t+1 (FETCH, commit_valid=0); next record valid at t+2.
- HALT: its commit is presented and fires like any other instruction. halted=1 the cycle after the fire; commit_valid then stays 0.
- retired increments on fire, including HALT. It holds at 2^CNT_W−1.

## Structure
- Shared package isa_pkg holds:
  - opcode constants and the INST_LEN derivation function;
  - the field-slice positions;
  - the FSM state enum {LOAD, FETCH, COMMIT, HALTED}.
- Sub-module isa_ref_exec is purely combinational: decode plus ALU, branch and memory-address computation. It takes the instruction, pc and operand values and produces the commit fields.
- The top level owns the memories, rf, FSM, record registers and counter.

## Test plan
- Load {LI r1,3; LI r2,5; ADD r3,r1,r2; HALT}, start, ready=1 → commits:
  - pc 0,1,2,3;
  - r3 data 8;
  - then halted=1 and retired=4.
- REG_LEN=4: LI r1,7; MUL r2,r1,r1 → commit_rd_data=1 (49 mod 16).
- ST then LD: memd addr 2 ← 9 via ST, then LD from addr 2 → commit_rd_data=9.
- BR when rf[rs2]==0 at pc 6 with offset 3 → commit_next_pc=1 (wrap).
  - Same BR with rf[rs2]≠0 → next_pc=7.
- Hold commit_ready=0 for 5 cycles → record stable and rf unchanged; it fires on the first ready cycle.
- Assert rst during COMMIT → commit_valid=0 next cycle, pc=0, retired=0, memd unchanged.
- Load strobe during FETCH → memi unchanged.
